// File: rtl/wr_req_arbiter.sv
// Round-robin arbiter sharing one CCI write-request channel among NUM_REQ sources.
// Tags mdata with the requester ID, steers responses back and tracks per-requester credit.
module wr_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int MAX_OUT     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pause,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*ADDR_LMT-1:0]       req_addr,
  input  logic [NUM_REQ*CACHE_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ*(MDATA-ID_W)-1:0]   req_mdata,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [ADDR_LMT-1:0]               wr_req_addr,
  output logic [MDATA-1:0]                  wr_req_mdata,
  output logic [CACHE_WIDTH-1:0]            wr_req_data,
  output logic                              wr_req_en,
  input  logic                              wr_req_almostfull,
  input  logic                              wr_rsp0_valid,
  input  logic [MDATA-1:0]                  wr_rsp0_mdata,
  input  logic                              wr_rsp1_valid,
  input  logic [MDATA-1:0]                  wr_rsp1_mdata,
  output logic [NUM_REQ-1:0]                rsp0_sel,
  output logic [NUM_REQ-1:0]                rsp1_sel,
  output logic [MDATA-ID_W-1:0]             rsp0_mdata,
  output logic [MDATA-ID_W-1:0]             rsp1_mdata,
  output logic                              idle,
  output logic                              err_underflow,
  output logic                              err_badid
);
  localparam int UW = MDATA - ID_W;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUT);

  logic [NUM_REQ-1:0][CW-1:0] r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0][CW:0]   w_up, w_dn, w_diff;
  logic [ID_W-1:0]            r_ptr, w_gid, w_id0, w_id1;
  logic [NUM_REQ-1:0]         w_elig, w_ready;
  logic                       w_gnt_en, w_xfer, w_uf, w_bad0, w_bad1, w_nxt_zero;
  logic [ADDR_LMT-1:0]        r_addr;
  logic [MDATA-1:0]           r_mdata;
  logic [CACHE_WIDTH-1:0]     r_data;
  logic                       r_en, r_idle, r_uf, r_bad;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NUM_REQ;
    return s[ID_W-1:0];
  endfunction

  // Search begins at r_ptr and wraps; first eligible requester wins.
  always_comb begin
    w_gnt_en = rst & ~pause & ~wr_req_almostfull;
    w_xfer   = 1'b0;
    w_gid    = '0;
    for (int i = 0; i < NUM_REQ; i++) w_elig[i] = req_valid[i] & (r_cnt[i] < MAXC);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_xfer && w_gnt_en && w_elig[wrap_idx(r_ptr, k)]) begin
        w_xfer = 1'b1;
        w_gid  = wrap_idx(r_ptr, k);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) w_ready[i] = w_xfer && (int'(w_gid) == i);
  end

  assign req_ready = w_ready;

  always_comb begin
    w_id0  = wr_rsp0_mdata[MDATA-1 -: ID_W];
    w_id1  = wr_rsp1_mdata[MDATA-1 -: ID_W];
    w_bad0 = wr_rsp0_valid && (int'(w_id0) >= NUM_REQ);
    w_bad1 = wr_rsp1_valid && (int'(w_id1) >= NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp0_sel[i] = wr_rsp0_valid && (int'(w_id0) == i);
      rsp1_sel[i] = wr_rsp1_valid && (int'(w_id1) == i);
    end
  end

  assign rsp0_mdata = wr_rsp0_mdata[UW-1:0];
  assign rsp1_mdata = wr_rsp1_mdata[UW-1:0];

  // Net change per requester is -2..+1; going below zero clamps and flags underflow.
  always_comb begin
    w_uf       = 1'b0;
    w_nxt_zero = 1'b1;
    w_up       = '0;
    w_dn       = '0;
    w_diff     = '0;
    w_cnt_nxt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_up[i]   = {1'b0, r_cnt[i]} + (CW+1)'(w_ready[i]);
      w_dn[i]   = (CW+1)'(rsp0_sel[i]) + (CW+1)'(rsp1_sel[i]);
      w_diff[i] = w_up[i] - w_dn[i];
      if (w_up[i] < w_dn[i]) begin
        w_uf         = 1'b1;
        w_cnt_nxt[i] = '0;
      end else begin
        w_cnt_nxt[i] = w_diff[i][CW-1:0];
      end
      if (w_cnt_nxt[i] != '0) w_nxt_zero = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_en    <= 1'b0;
      r_addr  <= '0;
      r_mdata <= '0;
      r_data  <= '0;
      r_idle  <= 1'b1;
      r_uf    <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_en  <= w_xfer;
      if (w_xfer) begin
        r_ptr   <= wrap_idx(w_gid, 1);
        r_addr  <= req_addr[int'(w_gid)*ADDR_LMT +: ADDR_LMT];
        r_data  <= req_data[int'(w_gid)*CACHE_WIDTH +: CACHE_WIDTH];
        r_mdata <= {w_gid, req_mdata[int'(w_gid)*UW +: UW]};
      end
      r_idle <= w_nxt_zero & ~w_xfer;
      r_uf   <= r_uf | w_uf;
      r_bad  <= r_bad | w_bad0 | w_bad1;
    end
  end

  assign wr_req_addr   = r_addr;
  assign wr_req_mdata  = r_mdata;
  assign wr_req_data   = r_data;
  assign wr_req_en     = r_en;
  assign idle          = r_idle;
  assign err_underflow = r_uf;
  assign err_badid     = r_bad;
endmodule

// File: tb/tb_wr_req_arbiter.sv
// Bench for wr_req_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the arbitration rules.
module tb_wr_req_arbiter;
  localparam int N = 4, IDW = 2, AL = 20, MD = 14, CWD = 512, MO = 8, UW = MD - IDW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, pause, af;
  logic [N-1:0]      valid;
  logic [N*AL-1:0]   req_addr;
  logic [N*CWD-1:0]  req_data;
  logic [N*UW-1:0]   req_mdata;
  logic [N-1:0]      req_ready;
  logic [AL-1:0]     wr_req_addr;
  logic [MD-1:0]     wr_req_mdata;
  logic [CWD-1:0]    wr_req_data;
  logic              wr_req_en;
  logic              v0, v1;
  logic [MD-1:0]     md0, md1;
  logic [N-1:0]      rsp0_sel, rsp1_sel;
  logic [UW-1:0]     rsp0_mdata, rsp1_mdata;
  logic              idle, err_underflow, err_badid;

  wr_req_arbiter #(.NUM_REQ(N), .ID_W(IDW), .ADDR_LMT(AL), .MDATA(MD),
                   .CACHE_WIDTH(CWD), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst), .pause(pause), .req_valid(valid), .req_addr(req_addr),
    .req_data(req_data), .req_mdata(req_mdata), .req_ready(req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
    .wr_req_en(wr_req_en), .wr_req_almostfull(af),
    .wr_rsp0_valid(v0), .wr_rsp0_mdata(md0), .wr_rsp1_valid(v1), .wr_rsp1_mdata(md1),
    .rsp0_sel(rsp0_sel), .rsp1_sel(rsp1_sel), .rsp0_mdata(rsp0_mdata), .rsp1_mdata(rsp1_mdata),
    .idle(idle), .err_underflow(err_underflow), .err_badid(err_badid));

  int checks = 0, errors = 0;

  // Reference model state
  int             m_cnt[N];
  int             m_ptr;
  bit             m_en, m_uf, m_bad, m_idle;
  logic [AL-1:0]  m_addr;
  logic [MD-1:0]  m_mdata;
  logic [CWD-1:0] m_data;

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r = '0;
    if (rst && !pause && !af)
      for (int k = 0; k < N; k++) begin
        int i = (m_ptr + k) % N;
        if (r == '0 && valid[i] && m_cnt[i] < MO) r[i] = 1'b1;
      end
    return r;
  endfunction

  function automatic logic [N-1:0] exp_sel(input logic v, input logic [MD-1:0] md);
    logic [N-1:0] s = '0;
    int id = int'(md[MD-1 -: IDW]);
    if (v && id < N) s[id] = 1'b1;
    return s;
  endfunction

  // Advance the model on the current inputs, then clock the DUT.
  task automatic tick();
    logic [N-1:0] g  = exp_ready();
    logic [N-1:0] s0 = exp_sel(v0, md0);
    logic [N-1:0] s1 = exp_sel(v1, md1);
    int tot = 0;
    if (!rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ptr = 0; m_en = 0; m_uf = 0; m_bad = 0;
      m_addr = '0; m_mdata = '0; m_data = '0;
    end else begin
      m_en = (g != '0);
      for (int i = 0; i < N; i++) begin
        int n;
        if (g[i]) begin
          m_addr  = req_addr[i*AL +: AL];
          m_data  = req_data[i*CWD +: CWD];
          m_mdata = {IDW'(i), req_mdata[i*UW +: UW]};
          m_ptr   = (i + 1) % N;
        end
        n = m_cnt[i] + (g[i] ? 1 : 0) - (s0[i] ? 1 : 0) - (s1[i] ? 1 : 0);
        if (n < 0) begin n = 0; m_uf = 1; end
        m_cnt[i] = n;
      end
      if (v0 && int'(md0[MD-1 -: IDW]) >= N) m_bad = 1;
      if (v1 && int'(md1[MD-1 -: IDW]) >= N) m_bad = 1;
    end
    foreach (m_cnt[i]) tot += m_cnt[i];
    m_idle = (tot == 0) && !m_en;
    @(posedge clk); #1;
  endtask

  task automatic randomize_payload();
    for (int j = 0; j < N*CWD/32; j++) req_data[j*32 +: 32] = $urandom;
    for (int j = 0; j < N; j++) begin
      req_addr[j*AL +: AL]  = AL'($urandom);
      req_mdata[j*UW +: UW] = UW'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 0; pause = 0; af = 0; valid = '0; v0 = 0; v1 = 0; md0 = '0; md1 = '0;
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; valid = 4'hF; pause = 0; af = 0; v0 = 0; v1 = 0;
    randomize_payload();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    tick();
    checks++; if ({wr_req_en, idle, err_underflow, err_badid} !== 4'b0100) begin errors++;
      $display("FAIL reset_flags got en/idle/uf/bad=%b exp=0100", {wr_req_en, idle, err_underflow, err_badid}); end
    checks++; if (wr_req_addr !== '0 || wr_req_mdata !== '0 || wr_req_data !== '0) begin errors++;
      $display("FAIL reset_regs addr=%h mdata=%h exp 0", wr_req_addr, wr_req_mdata); end
    rst = 1; valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    randomize_payload();
    valid = 4'hF;
    for (int k = 0; k < 9; k++) begin
      logic [N-1:0] e = 4'(1 << (k % 4));
      #1;
      checks++; if (req_ready !== e) begin errors++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, e); end
      tick();
      checks++; if (wr_req_en !== 1'b1 || wr_req_mdata[13:12] !== 2'(k % 4) ||
                    wr_req_addr !== req_addr[(k%4)*AL +: AL]) begin errors++;
        $display("FAIL rr_out k=%0d en=%b id=%0d addr=%h exp id=%0d", k, wr_req_en, wr_req_mdata[13:12], wr_req_addr, k % 4); end
    end
    valid = '0;
  endtask

  task automatic test_almostfull();
    do_reset();
    valid = 4'b0010; af = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL af_ready k=%0d got=%b exp=0000", k, req_ready); end
      tick();
      checks++; if (wr_req_en !== 1'b0) begin errors++; $display("FAIL af_en k=%0d got=%b exp=0", k, wr_req_en); end
    end
    af = 0; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL af_resume got=%b exp=0010", req_ready); end
    tick();
    checks++; if (wr_req_en !== 1'b1 || wr_req_mdata[13:12] !== 2'd1) begin errors++;
      $display("FAIL af_out en=%b id=%0d exp en=1 id=1", wr_req_en, wr_req_mdata[13:12]); end
    valid = '0;
  endtask

  task automatic test_credit();
    logic [UW-1:0] tag;
    do_reset();
    valid = 4'b0100;
    for (int k = 0; k < MO; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL credit_fill k=%0d got=%b exp=0100", k, req_ready); end
      tick();
    end
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL credit_block got=%b exp=0000", req_ready); end
    tick();
    tag = UW'($urandom);
    v0 = 1; md0 = {2'd2, tag}; #1;
    checks++; if (rsp0_sel !== 4'b0100 || rsp0_mdata !== tag || req_ready !== 4'b0000) begin errors++;
      $display("FAIL credit_rsp sel=%b tag=%h ready=%b exp sel=0100 tag=%h ready=0000", rsp0_sel, rsp0_mdata, req_ready, tag); end
    tick();
    v0 = 0; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL credit_resume got=%b exp=0100", req_ready); end
    tick();
    checks++; if (wr_req_en !== 1'b1 || err_underflow !== 1'b0) begin errors++;
      $display("FAIL credit_out en=%b uf=%b exp en=1 uf=0", wr_req_en, err_underflow); end
    valid = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    valid = 4'b0001;
    repeat (3) tick();
    v0 = 1; v1 = 1; md0 = {2'd0, 12'h123}; md1 = {2'd0, 12'h456}; #1;
    checks++; if (rsp0_sel !== 4'b0001 || rsp1_sel !== 4'b0001 || req_ready !== 4'b0001) begin errors++;
      $display("FAIL simul_sel s0=%b s1=%b ready=%b exp 0001", rsp0_sel, rsp1_sel, req_ready); end
    checks++; if (rsp1_mdata !== 12'h456) begin errors++; $display("FAIL simul_tag got=%h exp=456", rsp1_mdata); end
    tick();
    valid = '0;
    tick();   // both lanes again: cnt 2 -> 0 with no underflow
    v1 = 0;
    checks++; if (err_underflow !== 1'b0 || idle !== 1'b1) begin errors++;
      $display("FAIL simul_drain uf=%b idle=%b exp uf=0 idle=1", err_underflow, idle); end
    tick();
    v0 = 0;
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL simul_uf got=%b exp=1", err_underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    v1 = 1; md1 = {2'd3, 12'hABC}; #1;
    checks++; if (rsp1_sel !== 4'b1000) begin errors++; $display("FAIL uf_sel got=%b exp=1000", rsp1_sel); end
    tick();
    v1 = 0;
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set got=%b exp=1", err_underflow); end
    repeat (3) tick();
    checks++; if (err_underflow !== 1'b1 || idle !== 1'b1 || err_badid !== 1'b0) begin errors++;
      $display("FAIL uf_sticky uf=%b idle=%b bad=%b exp 1 1 0", err_underflow, idle, err_badid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid = 4'b0010;
    repeat (5) tick();
    valid = 4'hF; rst = 0; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rmid_ready got=%b exp=0000", req_ready); end
    tick();
    checks++; if (wr_req_en !== 1'b0 || idle !== 1'b1 || err_underflow !== 1'b0) begin errors++;
      $display("FAIL rmid_state en=%b idle=%b uf=%b exp 0 1 0", wr_req_en, idle, err_underflow); end
    rst = 1; valid = 4'b0110; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_first got=%b exp=0010", req_ready); end
    tick();
    valid = '0; v0 = 1; md0 = {2'd2, 12'h001};
    tick();
    v0 = 0;
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL rmid_uf got=%b exp=1", err_underflow); end
  endtask

  task automatic test_random();
    int id;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      randomize_payload();
      valid = N'($urandom);
      af    = ($urandom_range(0, 4) == 0);
      pause = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 199) != 0);
      id = $urandom_range(0, N-1);
      v0 = ($urandom_range(0, 2) == 0) && (m_cnt[id] > 0 || $urandom_range(0, 19) == 0);
      md0 = {IDW'(id), UW'($urandom)};
      id = $urandom_range(0, N-1);
      v1 = ($urandom_range(0, 2) == 0) && (m_cnt[id] > 0 || $urandom_range(0, 19) == 0);
      md1 = {IDW'(id), UW'($urandom)};
      #1;
      checks++; if (req_ready !== exp_ready()) begin errors++;
        $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready()); end
      checks++; if (rsp0_sel !== exp_sel(v0, md0) || rsp1_sel !== exp_sel(v1, md1) ||
                    rsp0_mdata !== md0[UW-1:0] || rsp1_mdata !== md1[UW-1:0]) begin errors++;
        $display("FAIL rnd_rsp c=%0d s0=%b s1=%b exp s0=%b s1=%b", c, rsp0_sel, rsp1_sel, exp_sel(v0, md0), exp_sel(v1, md1)); end
      tick();
      checks++; if ({wr_req_en, idle, err_underflow, err_badid} !== {m_en, m_idle, m_uf, m_bad}) begin errors++;
        $display("FAIL rnd_flags c=%0d en/idle/uf/bad got=%b exp=%b", c,
                 {wr_req_en, idle, err_underflow, err_badid}, {m_en, m_idle, m_uf, m_bad}); end
      checks++; if (wr_req_addr !== m_addr || wr_req_mdata !== m_mdata || wr_req_data !== m_data) begin errors++;
        $display("FAIL rnd_req c=%0d addr=%h mdata=%h exp addr=%h mdata=%h", c, wr_req_addr, wr_req_mdata, m_addr, m_mdata); end
    end
    rst = 1; valid = '0; v0 = 0; v1 = 0; af = 0; pause = 0;
  endtask

  initial begin
    rst = 0; pause = 0; af = 0; valid = '0; v0 = 0; v1 = 0; md0 = '0; md1 = '0;
    req_addr = '0; req_data = '0; req_mdata = '0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ptr = 0; m_en = 0; m_uf = 0; m_bad = 0; m_idle = 1;
    m_addr = '0; m_mdata = '0; m_data = '0;
    @(posedge clk); #1;
    test_reset();
    test_round_robin();
    test_almostfull();
    test_credit();
    test_simultaneous();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
